// File: rtl/atm_pin_checker.sv
// PIN entry/verification FSM: collects BCD digits, compares against the stored PIN,
// counts failed attempts and latches a lockout that only reset clears.
module atm_pin_checker #(
   parameter int DIGITS    = 4,
   parameter int MAX_TRIES = 3,
   parameter int TIMEOUT   = 200
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  card_in,
   input  logic                  digit_valid,
   input  logic [3:0]            digit,
   input  logic                  cancel,
   input  logic [4*DIGITS-1:0]   stored_pin,
   output logic                  pin_ok,
   output logic                  pin_fail,
   output logic                  entry_timeout,
   output logic                  card_locked,
   output logic [1:0]            tries_left,
   output logic                  busy
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DIGITS - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [7:0]    TO_LAST   = 8'(TIMEOUT - 1);
   localparam logic [1:0]    TRIES_MAX = 2'(MAX_TRIES);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ENTER   = 3'd1;
   localparam logic [2:0] S_CHECK   = 3'd2;
   localparam logic [2:0] S_GRANTED = 3'd3;
   localparam logic [2:0] S_LOCKED  = 3'd4;

   logic [2:0]    r_state, w_state;
   logic [BW-1:0] r_buf, w_buf;
   logic [CW-1:0] r_cnt, w_cnt;
   logic [7:0]    r_timer, w_timer;
   logic          r_pin_ok, w_pin_ok;
   logic          r_pin_fail, w_pin_fail;
   logic          r_timeout, w_timeout;
   logic          r_locked, w_locked;
   logic [1:0]    r_tries, w_tries;
   logic          r_busy, w_busy;
   logic          w_leave;
   logic          w_dig_ok;

   assign w_leave  = !card_in || cancel;
   assign w_dig_ok = digit_valid && (digit <= 4'd9);

   always_comb begin
      w_state    = r_state;
      w_buf      = r_buf;
      w_cnt      = r_cnt;
      w_timer    = r_timer;
      w_pin_ok   = r_pin_ok;
      w_pin_fail = 1'b0;
      w_timeout  = 1'b0;
      w_locked   = r_locked;
      w_tries    = r_tries;
      case (r_state)
         S_IDLE: begin
            w_buf    = '0;
            w_cnt    = '0;
            w_timer  = '0;
            w_pin_ok = 1'b0;
            if (card_in) w_state = S_ENTER;
         end
         S_ENTER: begin
            if (w_leave) begin
               w_state = S_IDLE;
               w_buf   = '0;
               w_cnt   = '0;
               w_timer = '0;
            end else if (w_dig_ok) begin
               w_buf   = (r_buf << 4) | BW'(digit);
               w_cnt   = r_cnt + CNT_ONE;
               w_timer = '0;
               if (r_cnt == CNT_LAST) w_state = S_CHECK;
            end else if (r_timer == TO_LAST) begin
               w_buf     = '0;
               w_cnt     = '0;
               w_timer   = '0;
               w_timeout = 1'b1;
            end else begin
               w_timer = r_timer + 8'd1;
            end
         end
         S_CHECK: begin
            w_buf   = '0;
            w_cnt   = '0;
            w_timer = '0;
            if (w_leave) begin
               w_state = S_IDLE;
            end else if (r_buf == stored_pin) begin
               w_state  = S_GRANTED;
               w_pin_ok = 1'b1;
               w_tries  = TRIES_MAX;
            end else begin
               w_pin_fail = 1'b1;
               w_tries    = (r_tries == 2'd0) ? 2'd0 : r_tries - 2'd1;
               // Last attempt consumed: lock in the same cycle as the fail pulse.
               if (r_tries <= 2'd1) begin
                  w_state  = S_LOCKED;
                  w_locked = 1'b1;
               end else begin
                  w_state = S_ENTER;
               end
            end
         end
         S_GRANTED: begin
            if (w_leave) begin
               w_state  = S_IDLE;
               w_pin_ok = 1'b0;
            end
         end
         S_LOCKED: begin
            w_pin_ok = 1'b0;
            w_locked = 1'b1;
         end
         default: w_state = S_IDLE;
      endcase
      w_busy = (w_state == S_ENTER) || (w_state == S_CHECK);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_buf      <= '0;
         r_cnt      <= '0;
         r_timer    <= '0;
         r_pin_ok   <= 1'b0;
         r_pin_fail <= 1'b0;
         r_timeout  <= 1'b0;
         r_locked   <= 1'b0;
         r_tries    <= TRIES_MAX;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_buf      <= w_buf;
         r_cnt      <= w_cnt;
         r_timer    <= w_timer;
         r_pin_ok   <= w_pin_ok;
         r_pin_fail <= w_pin_fail;
         r_timeout  <= w_timeout;
         r_locked   <= w_locked;
         r_tries    <= w_tries;
         r_busy     <= w_busy;
      end
   end

   assign pin_ok        = r_pin_ok;
   assign pin_fail      = r_pin_fail;
   assign entry_timeout = r_timeout;
   assign card_locked   = r_locked;
   assign tries_left    = r_tries;
   assign busy          = r_busy;

endmodule

// File: tb/tb_atm_pin_checker.sv
// Bench for atm_pin_checker: directed scenarios with literal expectations, then
// randomized traffic compared each cycle against a queue-based session model.
module tb_atm_pin_checker;

   localparam int DIGITS    = 4;
   localparam int MAX_TRIES = 3;
   localparam int TIMEOUT   = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        card_in;
   logic        digit_valid;
   logic [3:0]  digit;
   logic        cancel;
   logic [15:0] stored_pin;
   logic        pin_ok, pin_fail, entry_timeout, card_locked, busy;
   logic [1:0]  tries_left;

   atm_pin_checker #(.DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .card_in(card_in), .digit_valid(digit_valid),
      .digit(digit), .cancel(cancel), .stored_pin(stored_pin),
      .pin_ok(pin_ok), .pin_fail(pin_fail), .entry_timeout(entry_timeout),
      .card_locked(card_locked), .tries_left(tries_left), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // Session model: mode names mirror the protocol phases; entered digits live in a queue.
   localparam int M_IDLE = 0, M_ENTER = 1, M_CHECK = 2, M_GRANTED = 3, M_LOCKED = 4;
   int         m_mode;
   int         m_digits[$];
   int         m_idle;
   logic       e_ok, e_fail, e_to, e_locked, e_busy;
   logic [1:0] e_tries;

   task automatic model_reset();
      m_mode = M_IDLE; m_digits.delete(); m_idle = 0;
      e_ok = 0; e_fail = 0; e_to = 0; e_locked = 0; e_busy = 0; e_tries = 2'(MAX_TRIES);
   endtask

   task automatic model_step();
      logic [15:0] v;
      e_fail = 0; e_to = 0;
      case (m_mode)
         M_IDLE: begin
            m_digits.delete(); m_idle = 0;
            if (card_in) m_mode = M_ENTER;
         end
         M_ENTER: begin
            if (!card_in || cancel) begin
               m_mode = M_IDLE; m_digits.delete();
            end else if (digit_valid && digit < 10) begin
               m_digits.push_back(int'(digit)); m_idle = 0;
               if (m_digits.size() == DIGITS) m_mode = M_CHECK;
            end else begin
               m_idle++;
               if (m_idle == TIMEOUT) begin e_to = 1; m_digits.delete(); m_idle = 0; end
            end
         end
         M_CHECK: begin
            v = 0;
            foreach (m_digits[i]) v = (v << 4) | 16'(m_digits[i]);
            m_digits.delete(); m_idle = 0;
            if (!card_in || cancel) m_mode = M_IDLE;
            else if (v == stored_pin) begin
               m_mode = M_GRANTED; e_ok = 1; e_tries = 2'(MAX_TRIES);
            end else begin
               e_fail = 1;
               if (e_tries > 0) e_tries = e_tries - 2'd1;
               if (e_tries == 0) begin m_mode = M_LOCKED; e_locked = 1; end
               else m_mode = M_ENTER;
            end
         end
         M_GRANTED: if (!card_in || cancel) begin m_mode = M_IDLE; e_ok = 0; end
         default: ;
      endcase
      e_busy = (m_mode == M_ENTER) || (m_mode == M_CHECK);
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         n_tests++;
         if ({pin_ok, pin_fail, entry_timeout, card_locked, tries_left, busy} !==
             {e_ok, e_fail, e_to, e_locked, e_tries, e_busy}) begin
            n_fail++;
            $display("FAIL outputs t=%0t: got ok=%b fail=%b to=%b lk=%b tries=%0d busy=%b, required ok=%b fail=%b to=%b lk=%b tries=%0d busy=%b",
                     $time, pin_ok, pin_fail, entry_timeout, card_locked, tries_left, busy,
                     e_ok, e_fail, e_to, e_locked, e_tries, e_busy);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [3:0] d);
      digit_valid = 1'b1; digit = d;
      tick();
      digit_valid = 1'b0;
   endtask

   task automatic enter_pin(input logic [15:0] p);
      for (int i = 3; i >= 0; i--) send(p[i*4 +: 4]);
   endtask

   int rate;

   initial begin
      rst = 1'b1; card_in = 0; digit_valid = 0; digit = 0; cancel = 0; stored_pin = 16'h1234;
      tick(); tick();
      chk("reset_tries", int'(tries_left), 3);
      chk("reset_flags", int'({pin_ok, pin_fail, entry_timeout, card_locked, busy}), 0);
      rst = 1'b0;
      chk_en = 1'b1;

      // Correct PIN with two-cycle result latency
      card_in = 1; tick();
      enter_pin(16'h1234);
      chk("check_cycle_busy", int'(busy), 1);
      chk("check_cycle_no_ok", int'(pin_ok), 0);
      tick();
      chk("grant_ok", int'(pin_ok), 1);
      chk("grant_tries", int'(tries_left), 3);
      card_in = 0; tick();
      chk("card_out_ok", int'(pin_ok), 0);

      // Lockout after three wrong PINs
      card_in = 1; tick();
      for (int k = 0; k < 3; k++) begin
         enter_pin(16'h9999); tick();
         chk("lock_fail_pulse", int'(pin_fail), 1);
         chk("lock_tries", int'(tries_left), 2 - k);
         chk("lock_flag", int'(card_locked), (k == 2) ? 1 : 0);
      end
      card_in = 0; tick(); tick();
      card_in = 1; tick(); enter_pin(16'h1234); tick();
      chk("locked_persist", int'(card_locked), 1);
      chk("locked_no_ok", int'(pin_ok), 0);
      rst = 1; #1;
      chk("async_rst_lock", int'(card_locked), 0);
      chk("async_rst_tries", int'(tries_left), 3);
      tick(); rst = 0;

      // Fail then pass restores attempts
      tick();
      enter_pin(16'h1235); tick();
      chk("fp_fail", int'(pin_fail), 1);
      chk("fp_tries", int'(tries_left), 2);
      enter_pin(16'h1234); tick();
      chk("fp_ok", int'(pin_ok), 1);
      chk("fp_tries_restored", int'(tries_left), 3);
      card_in = 0; tick();

      // Invalid digit ignored; cancel beats a simultaneous digit
      card_in = 1; tick();
      send(4'h1); send(4'hA); send(4'h2); send(4'h3); send(4'h4); tick();
      chk("invalid_ignored_ok", int'(pin_ok), 1);
      card_in = 0; tick(); card_in = 1; tick();
      send(4'h1); send(4'h2); cancel = 1; send(4'h3); cancel = 0;
      chk("cancel_idle", int'(busy), 0);
      chk("cancel_no_fail", int'(pin_fail), 0);
      chk("cancel_tries", int'(tries_left), 3);

      // Timeout discards partial entry without consuming an attempt
      tick();
      send(4'h1); send(4'h2);
      repeat (TIMEOUT - 1) tick();
      chk("to_not_yet", int'(entry_timeout), 0);
      tick();
      chk("to_pulse", int'(entry_timeout), 1);
      chk("to_still_enter", int'(busy), 1);
      enter_pin(16'h1234); tick();
      chk("to_then_ok", int'(pin_ok), 1);
      chk("to_tries", int'(tries_left), 3);
      card_in = 0; tick();

      // Reset mid-entry and in GRANTED
      card_in = 1; tick(); send(4'h1); send(4'h2);
      rst = 1; #1;
      chk("rst_mid_busy", int'(busy), 0);
      tick(); rst = 0; tick();
      enter_pin(16'h1234); tick();
      chk("pre_rst_ok", int'(pin_ok), 1);
      rst = 1; #1;
      chk("rst_granted_ok", int'(pin_ok), 0);
      tick(); rst = 0;

      // Randomized traffic against the model
      rate = 50;
      for (int c = 0; c < 4000; c++) begin
         if (c % 100 == 0) rate = ($urandom_range(0, 1) != 0) ? 50 : 4;
         if (c % 500 == 0)
            for (int j = 0; j < 4; j++) stored_pin[j*4 +: 4] = 4'($urandom_range(1, 2));
         card_in     = ($urandom_range(0, 99) >= 2);
         cancel      = ($urandom_range(0, 99) < 2);
         digit_valid = ($urandom_range(0, 99) < rate);
         digit       = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 2));
         if ($urandom_range(0, 299) == 0) rst = 1;
         tick();
         rst = 0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/atm_pin_checker.md
# atm_pin_checker

Sequential PIN-entry and verification stage of the ATM bank system. Collects keypad digits for an inserted card, compares them against the account's stored PIN, tracks failed attempts, and locks the card after too many failures. Its `pin_ok` output is the authorisation term combined with the card-present term by the downstream AND gate that enables transactions.

## Interface
- `DIGITS`, 4: PIN length in BCD digits.
- `MAX_TRIES`, 3: failed attempts allowed before lockout (1..3).
- `TIMEOUT`, 200: idle cycles in ENTER before the partial entry is discarded (1..255).

One clock; reset is asynchronous and active-high.
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: asynchronous active-high reset.
- `card_in`  in  1: card present (level).
- `digit_valid`  in  1: one-cycle strobe, `digit` is valid.
- `digit`  in  4: BCD keypad digit.
- `cancel`  in  1: one-cycle cancel-key strobe.
- `stored_pin`  in  4*DIGITS: account PIN; first-entered digit is the MS nibble.
- `pin_ok`  out  1: PIN verified; held while the session lasts.
- `pin_fail`  out  1: one-cycle pulse per wrong PIN.
- `entry_timeout`  out  1: one-cycle pulse when a partial entry is discarded.
- `card_locked`  out  1: lockout active.
- `tries_left`  out  2: remaining attempts.
- `busy`  out  1: high in ENTER or CHECK.

## Operation
- States: IDLE, ENTER, CHECK, GRANTED, LOCKED. All outputs are registered.
- Reset values: state IDLE, `pin_ok`=0, `pin_fail`=0, `entry_timeout`=0, `card_locked`=0, `tries_left`=MAX_TRIES, `busy`=0. Digit buffer, digit count and timer are 0.
- **IDLE**
  - `card_in`=1 -> ENTER.
  - Buffer, count and timer cleared.
- **ENTER**
  - `digit_valid` with `digit`<=9: the digit shifts into the buffer LS nibble, the count increments, and the timer clears.
  - Digits >9 are ignored: no shift, no timer clear.
  - When the count reaches DIGITS -> CHECK.
  - With no accepted digit, the timer increments. At timer==TIMEOUT: buffer and count clear, `entry_timeout` pulses, and the state stays ENTER. No attempt is consumed.
- **CHECK** (exactly one cycle): compare the buffer with `stored_pin`.
  - Match -> GRANTED, `pin_ok`=1, `tries_left`=MAX_TRIES.
  - Mismatch: `pin_fail` pulses and `tries_left` decrements.
    - If the new value is 0 -> LOCKED.
    - Otherwise -> ENTER with the buffer cleared.
- **GRANTED**
  - `pin_ok` is held.
  - `card_in`=0 or `cancel` -> IDLE, `pin_ok`=0.
- **LOCKED**
  - `card_locked`=1 and `pin_ok`=0.
  - All inputs are ignored, including `card_in`. Only `rst` exits.
- Priority within a cycle: `card_in`=0, then `cancel`, then `digit_valid`, then timeout.
  - In ENTER or CHECK, `card_in`=0 or `cancel` -> IDLE with the partial entry discarded. No attempt is consumed, but `tries_left` keeps its value.
  - A pending CHECK result is discarded if `card_in` drops in that cycle.
- `tries_left` is restored only by `rst` or a successful match, so removing the card cannot bypass lockout.
- `tries_left` never goes below 0 and is never written with a value above MAX_TRIES.

## Timing
- The final digit is sampled at edge N; the state is CHECK after N.
- `pin_ok` or the `pin_fail` pulse becomes visible after edge N+1, i.e. 2 cycles after the final digit strobe.
- `card_locked` rises in the same cycle as the third `pin_fail` pulse.
- Digit strobes arriving in CHECK are dropped.
- ENTER is re-entered after a fail with the count at 0, so the next digit is accepted one cycle after the `pin_fail` pulse.
- Timeout fires TIMEOUT cycles after the last accepted digit, or after entry into ENTER.
- `rst` asynchronously forces reset values in any state, including mid-entry and LOCKED.

## Test plan
- Correct PIN: stored 0x1234, card inserted, digits 1,2,3,4 on consecutive cycles -> `pin_ok`=1 two cycles after digit 4, `tries_left`=3. Card removed -> `pin_ok`=0 next cycle, IDLE.
- Lockout: stored 0x1234, enter 9999 three times -> three `pin_fail` pulses, `tries_left` 2,1,0, `card_locked`=1 on the third. Removing and reinserting the card keeps `card_locked`=1. `rst` clears it and sets `tries_left`=3.
- Fail then pass: 1235 -> `pin_fail`, `tries_left`=2. Then 1234 -> `pin_ok`=1, `tries_left`=3.
- Invalid and simultaneous inputs: digits 1,0xA,2,3,4 -> 0xA ignored, `pin_ok`. `cancel` with `digit_valid` at digit 3 -> IDLE, no `pin_fail`, `tries_left` unchanged.
- Timeout: TIMEOUT=10, enter 1,2, then idle 10 cycles -> `entry_timeout` pulse, count 0. Then 1234 -> `pin_ok`, `tries_left`=3.
- Reset mid-operation: assert `rst` after 2 digits, and separately in GRANTED -> all outputs at reset values immediately, without waiting for a clock edge.
